// File: rtl/nios2core_pio_poller_pkg.sv
// nios2core_pio_poller_pkg: shared FSM type, register offset and count-width helper for the PIO poller
package nios2core_pio_poller_pkg;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;
  localparam logic [31:0] PIO_DATA_OFS = 32'h0;
  function automatic int cnt_w(input int debounce);
    return $clog2(debounce + 1);
  endfunction
endpackage

// File: rtl/nios2core_key_debounce.sv
// nios2core_key_debounce: accepts a new key level after DEBOUNCE identical samples and pulses its edges
module nios2core_key_debounce
  import nios2core_pio_poller_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);
  localparam int CW = cnt_w(DEBOUNCE);
  localparam logic [CW-1:0] MAXC = CW'(DEBOUNCE);
  logic [WIDTH-1:0] last;
  logic [CW-1:0] count, count_n;
  logic take;
  always_comb begin
    count_n = sample != last ? CW'(1) : count == MAXC ? count : count + CW'(1);
    take = sample_valid && count_n == MAXC && sample != key_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= '0;
      count <= '0;
      key_state <= '0;
      key_press <= '0;
      key_release <= '0;
    end else begin
      key_press <= take ? sample & ~key_state : '0;
      key_release <= take ? ~sample & key_state : '0;
      if (sample_valid) begin
        last <= sample;
        count <= count_n;
      end
      if (take) key_state <= sample;
    end
  end
endmodule

// File: rtl/nios2core_pio_poller.sv
// nios2core_pio_poller: Avalon-MM master polling a key/LED PIO and forwarding LED writes
module nios2core_pio_poller
  import nios2core_pio_poller_pkg::*;
#(
  parameter int          WIDTH    = 3,
  parameter int          POLL_DIV = 50000,
  parameter int          DEBOUNCE = 4,
  parameter logic [31:0] PIO_BASE = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [31:0]      avm_address,
  output logic             avm_read,
  output logic             avm_write,
  output logic [31:0]      avm_writedata,
  input  logic             avm_waitrequest,
  input  logic [31:0]      avm_readdata,
  input  logic             avm_readdatavalid,
  output logic [WIDTH-1:0] key_state,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release,
  input  logic [WIDTH-1:0] led_data,
  input  logic             led_valid,
  output logic             led_ready
);
  localparam int DW = $clog2(POLL_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(POLL_DIV - 1);
  state_t state, state_n;
  logic [DW-1:0] div;
  logic [WIDTH-1:0] buf_data;
  logic poll_pend, buf_full, ent_wr, tick, accept, unused_rd;
  assign tick = div == DIV_MAX;
  assign accept = led_valid && !buf_full;
  assign led_ready = ~buf_full;
  assign avm_address = PIO_BASE + PIO_DATA_OFS;
  assign avm_read = state == RD_REQ;
  assign avm_write = state == WR_REQ;
  assign unused_rd = ^(avm_readdata >> WIDTH);
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = buf_full ? WR_REQ : poll_pend ? RD_REQ : IDLE;
      RD_REQ:  state_n = avm_waitrequest ? RD_REQ : RD_WAIT;
      RD_WAIT: state_n = avm_readdatavalid ? IDLE : RD_WAIT;
      WR_REQ:  state_n = avm_waitrequest ? WR_REQ : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      div <= '0;
      poll_pend <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= '0;
      ent_wr <= 1'b0;
      avm_writedata <= '0;
    end else begin
      state <= state_n;
      div <= tick ? '0 : div + DW'(1);
      poll_pend <= (state == IDLE && state_n == RD_REQ) ? 1'b0 : tick ? 1'b1 : poll_pend;
      ent_wr <= state != WR_REQ && state_n == WR_REQ;
      buf_full <= accept ? 1'b1 : ent_wr ? 1'b0 : buf_full;
      if (accept) buf_data <= led_data;
      if (state != WR_REQ && state_n == WR_REQ) avm_writedata <= 32'(buf_data);
    end
  end
  nios2core_key_debounce #(
    .WIDTH(WIDTH),
    .DEBOUNCE(DEBOUNCE)
  ) u_deb (
    .clk(clk),
    .reset(reset),
    .sample(avm_readdata[WIDTH-1:0]),
    .sample_valid(state == RD_WAIT && avm_readdatavalid),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release)
  );
endmodule

// File: tb/tb_nios2core_pio_poller.sv
// tb_nios2core_pio_poller: directed table-driven bench with a zero-wait latency-1 PIO model
module tb_nios2core_pio_poller;
  localparam logic [31:0] BASE = 32'h0000_1000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] avm_address, avm_writedata, avm_readdata;
  logic avm_read, avm_write, avm_waitrequest, avm_readdatavalid;
  logic [2:0] key_state, key_press, key_release, led_data;
  logic led_valid = 1'b0;
  logic led_ready;
  logic [2:0] in_port = 3'b000;
  logic waitreq = 1'b0;
  logic lat2 = 1'b0;
  logic p1 = 1'b0, p2 = 1'b0;
  logic [2:0] d1 = 3'b000, d2 = 3'b000;
  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_rd = 0, n_wr = 0, n_pulse = 0, last_rd = 0, rd_gap = 0;
  typedef struct {
    logic [2:0] in;
    logic [2:0] st;
    logic [2:0] pr;
    logic [2:0] rl;
  } vec_t;
  vec_t vt[17];

  nios2core_pio_poller #(
    .WIDTH(3),
    .POLL_DIV(8),
    .DEBOUNCE(3),
    .PIO_BASE(BASE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_write(avm_write),
    .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .key_state(key_state),
    .key_press(key_press),
    .key_release(key_release),
    .led_data(led_data),
    .led_valid(led_valid),
    .led_ready(led_ready)
  );

  always #5 clk = ~clk;

  assign avm_waitrequest = waitreq;
  assign avm_readdatavalid = lat2 ? p2 : p1;
  assign avm_readdata = {29'b0, lat2 ? d2 : d1};

  always @(posedge clk) begin
    p1 <= avm_read && !avm_waitrequest;
    p2 <= p1;
    d1 <= in_port;
    d2 <= d1;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read && !avm_waitrequest) begin
      n_rd <= n_rd + 1;
      rd_gap <= cyc - last_rd;
      last_rd <= cyc;
    end
    if (avm_write && !avm_waitrequest) n_wr <= n_wr + 1;
    if (|{key_press, key_release}) n_pulse <= n_pulse + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_rdv(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = avm_readdatavalid;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s: got no readdatavalid expected one within 40 cycles", name);
    end
  endtask

  task automatic wait_read(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = avm_read;
    end
    if (!seen) begin
      n_chk++;
      $display("FAIL %s: got no avm_read expected one within 40 cycles", name);
    end
  endtask

  initial begin
    int n0;
    led_data = 3'b000;
    vt[0]  = '{3'b101, 3'b000, 3'b000, 3'b000};
    vt[1]  = '{3'b101, 3'b000, 3'b000, 3'b000};
    vt[2]  = '{3'b101, 3'b101, 3'b101, 3'b000};
    vt[3]  = '{3'b000, 3'b101, 3'b000, 3'b000};
    vt[4]  = '{3'b101, 3'b101, 3'b000, 3'b000};
    vt[5]  = '{3'b000, 3'b101, 3'b000, 3'b000};
    vt[6]  = '{3'b101, 3'b101, 3'b000, 3'b000};
    vt[7]  = '{3'b000, 3'b101, 3'b000, 3'b000};
    vt[8]  = '{3'b000, 3'b101, 3'b000, 3'b000};
    vt[9]  = '{3'b000, 3'b000, 3'b000, 3'b101};
    vt[10] = '{3'b011, 3'b000, 3'b000, 3'b000};
    vt[11] = '{3'b011, 3'b000, 3'b000, 3'b000};
    vt[12] = '{3'b011, 3'b011, 3'b011, 3'b000};
    vt[13] = '{3'b110, 3'b011, 3'b000, 3'b000};
    vt[14] = '{3'b110, 3'b011, 3'b000, 3'b000};
    vt[15] = '{3'b110, 3'b110, 3'b100, 3'b001};
    vt[16] = '{3'b110, 3'b110, 3'b000, 3'b000};
    repeat (3) @(negedge clk);
    chk("rst_read", 32'(avm_read), 0);
    chk("rst_write", 32'(avm_write), 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_state", 32'(key_state), 0);
    chk("rst_pulses", 32'({key_press, key_release}), 0);
    chk("rst_ready", 32'(led_ready), 1);
    chk("rst_addr", avm_address, BASE);
    reset = 1'b0;
    n0 = n_rd;
    repeat (40) @(negedge clk);
    chk("idle_reads", 32'(n_rd - n0), 4);
    chk("idle_gap", 32'(rd_gap), 8);
    chk("idle_writes", 32'(n_wr), 0);
    chk("idle_pulses", 32'(n_pulse), 0);
    chk("idle_state", 32'(key_state), 0);
    wait_rdv("sync");
    foreach (vt[k]) begin
      in_port = vt[k].in;
      wait_rdv($sformatf("vec%0d_wait", k));
      @(negedge clk);
      chk($sformatf("vec%0d_state", k), 32'(key_state), 32'(vt[k].st));
      chk($sformatf("vec%0d_press", k), 32'(key_press), 32'(vt[k].pr));
      chk($sformatf("vec%0d_release", k), 32'(key_release), 32'(vt[k].rl));
      @(negedge clk);
      chk($sformatf("vec%0d_pulse_end", k), 32'({key_press, key_release}), 0);
    end
    wait_read("led_sync");
    repeat (6) @(negedge clk);
    led_data = 3'b110;
    led_valid = 1'b1;
    chk("led_accept_ready", 32'(led_ready), 1);
    @(negedge clk);
    led_valid = 1'b0;
    chk("led_low1_ready", 32'(led_ready), 0);
    chk("led_low1_write", 32'(avm_write), 0);
    chk("led_low1_read", 32'(avm_read), 0);
    @(negedge clk);
    chk("led_wr_strobe", 32'(avm_write), 1);
    chk("led_wr_data", avm_writedata, 32'h6);
    chk("led_wr_addr", avm_address, BASE);
    chk("led_wr_noread", 32'(avm_read), 0);
    chk("led_low2_ready", 32'(led_ready), 0);
    @(negedge clk);
    chk("led_ready_back", 32'(led_ready), 1);
    chk("led_wr_done", 32'(avm_write), 0);
    @(negedge clk);
    chk("led_read_follows", 32'(avm_read), 1);
    repeat (2) @(negedge clk);
    waitreq = 1'b1;
    n0 = n_rd;
    wait_read("stall_read");
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("stall_read%0d", i), 32'(avm_read), 1);
      chk($sformatf("stall_addr%0d", i), avm_address, BASE);
      if (i == 5) waitreq = 1'b0;
    end
    @(negedge clk);
    chk("stall_released", 32'(avm_read), 0);
    @(negedge clk);
    chk("stall_one_read", 32'(n_rd - n0), 1);
    chk("stall_no_reissue", 32'(avm_read), 0);
    lat2 = 1'b1;
    in_port = 3'b111;
    wait_read("rst_mid_read");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_read", 32'(avm_read), 0);
    chk("rstmid_write", 32'(avm_write), 0);
    chk("rstmid_wdata", avm_writedata, 0);
    chk("rstmid_state", 32'(key_state), 0);
    chk("rstmid_pulses", 32'({key_press, key_release}), 0);
    chk("rstmid_ready", 32'(led_ready), 1);
    @(negedge clk);
    lat2 = 1'b0;
    chk("rstmid_ignored", 32'(key_state), 0);
    chk("rstmid_idle", 32'(avm_read), 0);
    for (int i = 0; i < 3; i++) begin
      wait_rdv($sformatf("post_rst%0d_wait", i));
      @(negedge clk);
      chk($sformatf("post_rst%0d_state", i), 32'(key_state), i == 2 ? 32'h7 : 32'h0);
      chk($sformatf("post_rst%0d_press", i), 32'(key_press), i == 2 ? 32'h7 : 32'h0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
